// File: rtl/sat_addsub_serial.sv
// sat_addsub_serial
//
// Nibble-serial 16-bit signed adder/subtractor with saturation.
// A single start pulse latches the operands and the operation. The datapath
// then walks four 4-bit nibbles, least-significant nibble first, one per clock.
// The finished result is clamped to the signed 16-bit range if it overflows.
//
// Ports
//   clk    in   1   rising-edge clock for all state
//   rst    in   1   synchronous active-high reset
//   start  in   1   begin an operation (only looked at while idle)
//   A      in  16   signed operand A
//   B      in  16   signed operand B
//   sub    in   1   0: A+B, 1: A-B
//   busy   out  1   operation in flight (CALC or DONE)
//   done   out  1   one-cycle pulse, Sum/Error valid
//   Sum    out 16   saturated signed result, held until the next result
//   Error  out  1   overflow occurred and Sum is saturated

module sat_addsub_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic        Error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] a_reg;
  logic [15:0] bp_reg;
  logic [1:0]  cnt;
  logic        carry;
  logic [11:0] raw_lo;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  partial;
  logic [15:0] raw;
  logic        ovf;
  logic [15:0] sat_val;

  // State register; reset always wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. start is only honoured in IDLE, so a pulse during
  // CALC or DONE is dropped rather than queued.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == DONE);
  assign done = (state == DONE);

  // One nibble slice of the ripple adder. B is stored already conditionally
  // inverted. The carry register starts at sub, which completes the two's-
  // complement negation, so B=8000 needs no special-case handling.
  // The full raw word only exists combinationally while the top nibble is
  // being added.
  always_comb begin
    a_nib   = a_reg[{cnt, 2'b00} +: 4];
    b_nib   = bp_reg[{cnt, 2'b00} +: 4];
    partial = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    raw     = {partial[3:0], raw_lo};
    ovf     = (a_reg[15] == bp_reg[15]) && (raw[15] != a_reg[15]);
    sat_val = a_reg[15] ? 16'h8000 : 16'h7FFF;
  end

  // Operand capture, nibble accumulation and result update. Sum and Error
  // only change on the CALC -> DONE edge (or on reset).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= 16'h0000;
      bp_reg <= 16'h0000;
      cnt    <= 2'd0;
      carry  <= 1'b0;
      raw_lo <= 12'h000;
      Sum    <= 16'h0000;
      Error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= A;
            bp_reg <= sub ? ~B : B;
            cnt    <= 2'd0;
            carry  <= sub;
            raw_lo <= 12'h000;
          end
        end
        CALC: begin
          carry <= partial[4];
          cnt   <= cnt + 2'd1;
          case (cnt)
            2'd0: raw_lo[3:0]  <= partial[3:0];
            2'd1: raw_lo[7:4]  <= partial[3:0];
            2'd2: raw_lo[11:8] <= partial[3:0];
            default: begin
              Sum   <= ovf ? sat_val : raw;
              Error <= ovf;
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule
